// File: rtl/mem_stage_sram_ctrl.sv
// ----------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// Memory-stage controller between the EX/MEM pipeline register and an
// off-chip asynchronous SRAM. It acts on the load/store enables of the
// instruction in EX/MEM and runs one fixed-length access per request.
// While the access runs, the pipeline is frozen through 'ready'. Load data
// is registered on 'rdata' for the MEM/WB register.
//
// Each access walks IDLE -> ACCESS -> DONE -> IDLE:
//   IDLE   : ready drops in the same cycle as the request, which starts the
//            freeze at once. Address, data and direction are captured at
//            the end of this cycle.
//   ACCESS : the chip is selected for WAIT_CYCLES cycles with stable
//            address and data. A load samples the SRAM on the last edge.
//   DONE   : ready is high for one cycle, so the pipeline advances. The
//            inputs still show the instruction that just finished, so this
//            state ignores them.
// The pipeline freezes for 1 + WAIT_CYCLES cycles per access.
//
// Parameters
//   DATA_W       data width of the pipeline and the SRAM
//   SRAM_AW      SRAM word-address width (SRAM_AW + 2 <= DATA_W)
//   BASE_ADDR    byte address that maps to SRAM word 0
//   WAIT_CYCLES  SRAM cycles per transfer, legal range 1..15
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   mem_r_en     load request, held by the frozen pipeline until ready
//   mem_w_en     store request, held by the frozen pipeline until ready
//   addr         byte address (ALU result)
//   wdata        store data
//   rdata        registered load data; changes only when a load completes
//   ready        1 = pipeline may advance, 0 = freeze all stages
//   sram_addr    registered SRAM word address
//   sram_wdata   registered data driven to the SRAM
//   sram_rdata   data returned by the SRAM
//   sram_ce_n    chip enable, active low
//   sram_we_n    write enable, active low
//   sram_oe_n    output enable, active low
// ----------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
    parameter int          DATA_W      = 32,
    parameter int          SRAM_AW     = 17,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int          WAIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [DATA_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    input  logic [DATA_W-1:0]  sram_rdata,
    output logic               sram_ce_n,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Counter value on the final ACCESS cycle.
    localparam logic [3:0]        CNT_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [DATA_W-1:0] BASE     = DATA_W'(BASE_ADDR);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         state_q,      state_d;
    logic [3:0]         cnt_q,        cnt_d;
    logic               op_write_q,   op_write_d;
    logic [SRAM_AW-1:0] sram_addr_q,  sram_addr_d;
    logic [DATA_W-1:0]  sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0]  rdata_q,      rdata_d;

    logic               req;
    logic [DATA_W-1:0]  addr_off;

    logic               ready_c;
    logic               ce_n_c;
    logic               we_n_c;
    logic               oe_n_c;

    assign req = mem_r_en | mem_w_en;

    // The subtraction wraps modulo 2^DATA_W. An address below the base
    // therefore maps to the top of the SRAM. No range check is made.
    assign addr_off = addr - BASE;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement.
        // Paths that do not assign a variable then hold its value, and no
        // latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_write_d   = op_write_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d      = ST_ACCESS;
                    cnt_d        = 4'd0;
                    // A request with both enables set is a store.
                    op_write_d   = mem_w_en;
                    // The mapped word address is registered now. It then
                    // stays stable through ACCESS and holds afterwards.
                    sram_addr_d  = SRAM_AW'(addr_off >> 2);
                    sram_wdata_d = wdata;
                end
            end

            ST_ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    // Only a completed load updates rdata.
                    if (!op_write_q) begin
                        rdata_d = sram_rdata;
                    end
                end
            end

            // The inputs still carry the finished instruction here.
            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode (Moore strobes, Mealy ready in IDLE)
    // ------------------------------------------------------------------------
    always_comb begin
        ready_c = 1'b1;
        ce_n_c  = 1'b1;
        we_n_c  = 1'b1;
        oe_n_c  = 1'b1;

        case (state_q)
            // While rst_n is low, ready stays 1 even if a request is
            // still present on the inputs.
            ST_IDLE:   ready_c = ~req | ~rst_n;
            ST_ACCESS: begin
                ready_c = 1'b0;
                ce_n_c  = 1'b0;
                we_n_c  = ~op_write_q;
                oe_n_c  = op_write_q;
            end
            ST_DONE:   ready_c = 1'b1;
            default:   ready_c = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // therefore sample their _d values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            op_write_q   <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_write_q   <= op_write_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rdata      = rdata_q;
    assign ready      = ready_c;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_ce_n  = ce_n_c;
    assign sram_we_n  = we_n_c;
    assign sram_oe_n  = oe_n_c;

endmodule
